// File: rtl/bp_resolve.sv
// Branch-prediction resolve queue.
// Keeps the BTB prediction for each fetched instruction in fetch order. When
// EX resolves the oldest in-flight instruction, the queue compares that
// prediction with the real outcome, trains the BTB and redirects fetch on a
// mispredict.

package riscv_pkg;
    parameter int XLEN = 32;
endpackage

module bp_resolve
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       pred_valid,
    input  logic [XLEN-1:0]            pred_pc,
    input  logic                       pred_hit,
    input  logic [XLEN-1:0]            pred_target,
    output logic                       pred_ready,
    input  logic                       res_valid,
    input  logic                       res_is_cf,
    input  logic                       res_taken,
    input  logic [XLEN-1:0]            res_target,
    output logic                       update_en,
    output logic                       is_branch_or_jmp,
    output logic [XLEN-1:0]            pc_update,
    output logic [XLEN-1:0]            target_update,
    output logic                       redirect_valid,
    output logic [XLEN-1:0]            redirect_pc,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       underflow_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    // Handshake: a push transfers on a rising edge where pred_valid and
    // pred_ready are both high. pred_ready looks only at the registered
    // count, so a full queue refuses a push even when it pops that cycle.
    // There is no ready on the resolve side: EX must only resolve
    // instructions that were pushed, and a resolve on an empty queue is
    // reported on underflow_err.

    logic [XLEN-1:0] pc_mem_q  [DEPTH];
    logic            hit_mem_q [DEPTH];
    logic [XLEN-1:0] tgt_mem_q [DEPTH];

    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic            update_en_q, update_en_d;
    logic            is_br_q, is_br_d;
    logic [XLEN-1:0] pc_update_q, pc_update_d;
    logic [XLEN-1:0] target_update_q, target_update_d;
    logic            redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic            underflow_q, underflow_d;

    logic            push_ok;
    logic            pop;
    logic [XLEN-1:0] head_pc;
    logic            head_hit;
    logic [XLEN-1:0] head_tgt;
    logic [XLEN-1:0] fallthrough;
    logic [XLEN-1:0] actual_next;
    logic [XLEN-1:0] pred_next;
    logic            cf_taken;
    logic            mispredict;
    logic            train;

    assign pred_ready = reset && (count_q < CW'(DEPTH));
    assign push_ok    = pred_valid && pred_ready;
    assign pop        = res_valid && (count_q != '0);

    // Head entry and the prediction check against the resolved outcome.
    assign head_pc     = pc_mem_q[rd_ptr_q];
    assign head_hit    = hit_mem_q[rd_ptr_q];
    assign head_tgt    = tgt_mem_q[rd_ptr_q];
    assign fallthrough = head_pc + XLEN'(4);
    assign cf_taken    = res_is_cf && res_taken;
    assign actual_next = cf_taken ? res_target : fallthrough;
    assign pred_next   = head_hit ? head_tgt : fallthrough;
    assign mispredict  = actual_next != pred_next;
    assign train       = cf_taken && (!head_hit || (head_tgt != res_target));

    // Prediction storage; entries beyond the pointers are don't-care so no reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            pc_mem_q[wr_ptr_q]  <= pred_pc;
            hit_mem_q[wr_ptr_q] <= pred_hit;
            tgt_mem_q[wr_ptr_q] <= pred_target;
        end
    end

    // Next-state: flush beats everything, a mispredict drops the wrong path.
    always_comb begin
        rd_ptr_d         = rd_ptr_q;
        wr_ptr_d         = wr_ptr_q;
        count_d          = count_q;
        update_en_d      = 1'b0;
        is_br_d          = 1'b0;
        pc_update_d      = pc_update_q;
        target_update_d  = target_update_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        underflow_d      = 1'b0;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            underflow_d = res_valid && (count_q == '0);
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
                if (train) begin
                    update_en_d     = 1'b1;
                    is_br_d         = 1'b1;
                    pc_update_d     = head_pc;
                    target_update_d = res_target;
                end
                if (mispredict) begin
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = actual_next;
                end
            end
            if (pop && mispredict) begin
                rd_ptr_d = '0;
                wr_ptr_d = '0;
                count_d  = '0;
            end else begin
                if (push_ok) begin
                    wr_ptr_d = wr_ptr_q + AW'(1);
                end
                count_d = count_q + CW'(push_ok) - CW'(pop);
            end
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr_q         <= '0;
            wr_ptr_q         <= '0;
            count_q          <= '0;
            update_en_q      <= 1'b0;
            is_br_q          <= 1'b0;
            pc_update_q      <= '0;
            target_update_q  <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            underflow_q      <= 1'b0;
        end else begin
            rd_ptr_q         <= rd_ptr_d;
            wr_ptr_q         <= wr_ptr_d;
            count_q          <= count_d;
            update_en_q      <= update_en_d;
            is_br_q          <= is_br_d;
            pc_update_q      <= pc_update_d;
            target_update_q  <= target_update_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            underflow_q      <= underflow_d;
        end
    end

    assign update_en        = update_en_q;
    assign is_branch_or_jmp = is_br_q;
    assign pc_update        = pc_update_q;
    assign target_update    = target_update_q;
    assign redirect_valid   = redirect_valid_q;
    assign redirect_pc      = redirect_pc_q;
    assign count            = count_q;
    assign underflow_err    = underflow_q;

endmodule

// File: tb/tb_bp_resolve.sv
// Self-checking bench for bp_resolve: a reference queue model predicts the
// registered outputs of every cycle, the expectation is queued when the
// stimulus is driven and compared one edge later.

module tb_bp_resolve;
    import riscv_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic            flush;
    logic            pred_valid;
    logic [XLEN-1:0] pred_pc;
    logic            pred_hit;
    logic [XLEN-1:0] pred_target;
    logic            pred_ready;
    logic            res_valid;
    logic            res_is_cf;
    logic            res_taken;
    logic [XLEN-1:0] res_target;
    logic            update_en;
    logic            is_branch_or_jmp;
    logic [XLEN-1:0] pc_update;
    logic [XLEN-1:0] target_update;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic [CW-1:0]   count;
    logic            underflow_err;

    bp_resolve #(.DEPTH(DEPTH)) dut (
        .clk              (clk),
        .reset            (rst_n),
        .flush            (flush),
        .pred_valid       (pred_valid),
        .pred_pc          (pred_pc),
        .pred_hit         (pred_hit),
        .pred_target      (pred_target),
        .pred_ready       (pred_ready),
        .res_valid        (res_valid),
        .res_is_cf        (res_is_cf),
        .res_taken        (res_taken),
        .res_target       (res_target),
        .update_en        (update_en),
        .is_branch_or_jmp (is_branch_or_jmp),
        .pc_update        (pc_update),
        .target_update    (target_update),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .count            (count),
        .underflow_err    (underflow_err)
    );

    // ---------------- scoreboard ----------------
    typedef struct {
        logic            upd;
        logic [XLEN-1:0] pcu;
        logic [XLEN-1:0] tgu;
        logic            redir;
        logic [XLEN-1:0] rpc;
        logic            uf;
        int              cnt;
    } exp_t;

    exp_t exp_q[$];

    // Reference queue of outstanding predictions.
    logic [XLEN-1:0] m_pc[$];
    logic            m_hit[$];
    logic [XLEN-1:0] m_tgt[$];

    // Held data outputs of the model.
    logic [XLEN-1:0] m_pcu = '0;
    logic [XLEN-1:0] m_tgu = '0;
    logic [XLEN-1:0] m_rpc = '0;

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [XLEN-1:0] obs,
                             input logic [XLEN-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    // Drive one cycle of stimulus, predict its effect, clock, and compare.
    task automatic step(input logic pv, input logic [XLEN-1:0] ppc, input logic phit,
                        input logic [XLEN-1:0] ptgt, input logic rv, input logic cf,
                        input logic tk, input logic [XLEN-1:0] rtgt, input logic fl);
        exp_t            e;
        logic            exp_ready;
        logic            push;
        logic            mis;
        logic [XLEN-1:0] hpc, htgt, fall, act, prd;
        logic            hhit;

        pred_valid  = pv;
        pred_pc     = ppc;
        pred_hit    = phit;
        pred_target = ptgt;
        res_valid   = rv;
        res_is_cf   = cf;
        res_taken   = tk;
        res_target  = rtgt;
        flush       = fl;
        #1;
        exp_ready = rst_n && (m_pc.size() < DEPTH);
        check_val("pred_ready", XLEN'(pred_ready), XLEN'(exp_ready));

        e.upd   = 1'b0;
        e.redir = 1'b0;
        e.uf    = 1'b0;
        if (!rst_n) begin
            m_pc.delete(); m_hit.delete(); m_tgt.delete();
            m_pcu = '0; m_tgu = '0; m_rpc = '0;
        end else if (fl) begin
            m_pc.delete(); m_hit.delete(); m_tgt.delete();
        end else begin
            push = pv && exp_ready;
            mis  = 1'b0;
            if (rv && m_pc.size() == 0) e.uf = 1'b1;
            if (rv && m_pc.size() > 0) begin
                hpc  = m_pc.pop_front();
                hhit = m_hit.pop_front();
                htgt = m_tgt.pop_front();
                fall = hpc + 32'd4;
                act  = (cf && tk) ? rtgt : fall;
                prd  = hhit ? htgt : fall;
                mis  = (act != prd);
                if (cf && tk && (!hhit || htgt != rtgt)) begin
                    e.upd = 1'b1;
                    m_pcu = hpc;
                    m_tgu = rtgt;
                end
                if (mis) begin
                    e.redir = 1'b1;
                    m_rpc   = act;
                    m_pc.delete(); m_hit.delete(); m_tgt.delete();
                end
            end
            if (push && !mis) begin
                m_pc.push_back(ppc);
                m_hit.push_back(phit);
                m_tgt.push_back(ptgt);
            end
        end
        e.pcu = m_pcu;
        e.tgu = m_tgu;
        e.rpc = m_rpc;
        e.cnt = m_pc.size();
        exp_q.push_back(e);

        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_val("update_en",        XLEN'(update_en),        XLEN'(e.upd));
        check_val("is_branch_or_jmp", XLEN'(is_branch_or_jmp), XLEN'(e.upd));
        check_val("pc_update",        pc_update,               e.pcu);
        check_val("target_update",    target_update,           e.tgu);
        check_val("redirect_valid",   XLEN'(redirect_valid),   XLEN'(e.redir));
        check_val("redirect_pc",      redirect_pc,             e.rpc);
        check_val("underflow_err",    XLEN'(underflow_err),    XLEN'(e.uf));
        check_val("count",            XLEN'(count),            XLEN'(e.cnt));
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic push_only(input logic [XLEN-1:0] pc, input logic hit,
                             input logic [XLEN-1:0] tgt);
        step(1'b1, pc, hit, tgt, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic res_only(input logic cf, input logic tk, input logic [XLEN-1:0] tgt);
        step(1'b0, '0, 1'b0, '0, 1'b1, cf, tk, tgt, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        idle();
        idle();
        rst_n = 1'b1;

        // Non-control-flow instruction: nothing to train or redirect.
        push_only(32'h100, 1'b0, '0);
        res_only(1'b0, 1'b0, '0);
        idle();

        // Taken jump missed by the BTB: train and redirect together.
        push_only(32'h200, 1'b0, '0);
        res_only(1'b1, 1'b1, 32'h400);
        idle();

        // Predicted-taken branch falls through: redirect to pc+4, drop wrong path.
        push_only(32'h300, 1'b1, 32'h500);
        push_only(32'h304, 1'b0, '0);
        push_only(32'h308, 1'b0, '0);
        res_only(1'b1, 1'b0, '0);
        idle();

        // Fill to DEPTH; push+pop while full refuses the push; correct hit.
        push_only(32'h700, 1'b1, 32'h800);
        push_only(32'h704, 1'b0, '0);
        push_only(32'h708, 1'b0, '0);
        push_only(32'h70c, 1'b0, '0);
        step(1'b1, 32'h710, 1'b0, '0, 1'b1, 1'b1, 1'b1, 32'h800, 1'b0);
        res_only(1'b0, 1'b0, '0);
        res_only(1'b0, 1'b0, '0);
        res_only(1'b0, 1'b0, '0);

        // Resolve on empty queue, then flush against a mispredicting resolve.
        res_only(1'b1, 1'b1, 32'h999);
        idle();
        push_only(32'ha00, 1'b0, '0);
        push_only(32'ha04, 1'b0, '0);
        push_only(32'ha08, 1'b0, '0);
        step(1'b1, 32'ha0c, 1'b0, '0, 1'b1, 1'b1, 1'b1, 32'hb00, 1'b1);
        idle();

        // pc+4 wraps to zero.
        push_only(32'hffff_fffc, 1'b0, '0);
        res_only(1'b0, 1'b0, '0);

        // Reset in the middle of operation discards entries and data outputs.
        push_only(32'hc00, 1'b0, '0);
        push_only(32'hc04, 1'b0, '0);
        rst_n = 1'b0;
        idle();
        rst_n = 1'b1;
        res_only(1'b0, 1'b0, '0);

        // Random traffic over a small address/target space.
        for (int i = 0; i < 400; i++) begin
            logic [XLEN-1:0] rpc_pick, tg_pick;
            rst_n    = ($urandom_range(0, 99) != 0);
            rpc_pick = 32'h1000 + 32'($urandom_range(0, 7)) * 4;
            tg_pick  = 32'h2000 + 32'($urandom_range(0, 3)) * 4;
            step($urandom_range(0, 3) != 0, rpc_pick, 1'($urandom_range(0, 1)), tg_pick,
                 $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 32'h2000 + 32'($urandom_range(0, 3)) * 4,
                 $urandom_range(0, 24) == 0);
        end
        rst_n = 1'b1;
        idle();

        // ---------------- report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
